// File: rtl/regfile_dump_reader.sv
// Walks every register-file address through the spare read port and streams
// (address, data) beats on a valid/ready interface. Define REGFILE_DUMP_SKIP_X0_EN to start at x1.
module regfile_dump_reader #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic                     abort_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [ADDRESS_WIDTH-1:0] rf_addr_o,
   input  logic [DATA_WIDTH-1:0]    rf_data_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [ADDRESS_WIDTH-1:0] out_addr_o,
   output logic [DATA_WIDTH-1:0]    out_data_o
);

   typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

`ifdef REGFILE_DUMP_SKIP_X0_EN
   localparam logic [ADDRESS_WIDTH-1:0] FIRST = ADDRESS_WIDTH'(1);
`else
   localparam logic [ADDRESS_WIDTH-1:0] FIRST = '0;
`endif
   localparam logic [ADDRESS_WIDTH-1:0] LAST = '1;

   state_t                     state, state_next;
   logic [ADDRESS_WIDTH-1:0]   cnt, cnt_next;
   logic [ADDRESS_WIDTH-1:0]   out_addr_q;
   logic [DATA_WIDTH-1:0]      out_data_q;
   logic                       capture;
   logic                       handshake;

   assign handshake = (state == SEND) && out_ready_i;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         cnt   <= FIRST;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Beat registers are reset so the stream outputs read 0 out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_addr_q <= '0;
         out_data_q <= '0;
      end else if (capture) begin
         out_addr_q <= cnt;
         out_data_q <= rf_data_i;
      end
   end

   // NOTE: every signal written here gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_i) begin
               state_next = READ;
               cnt_next   = FIRST;
            end
         end
         READ: begin
            capture    = 1'b1;
            state_next = SEND;
         end
         SEND: begin
            if (handshake) begin
               if (cnt == LAST) begin
                  state_next = FIN;
               end else begin
                  cnt_next   = cnt + ADDRESS_WIDTH'(1);
                  state_next = READ;
               end
            end
         end
         FIN: begin
            state_next = IDLE;
            cnt_next   = FIRST;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = FIRST;
         end
      endcase
      // Abort overrides everything, including a same-cycle handshake; in IDLE
      // it also suppresses a simultaneous start.
      if (abort_i) begin
         state_next = IDLE;
         cnt_next   = FIRST;
         capture    = 1'b0;
      end
   end

   assign busy_o      = (state != IDLE);
   assign done_o      = (state == FIN);
   assign out_valid_o = (state == SEND);
   assign rf_addr_o   = cnt;
   assign out_addr_o  = out_addr_q;
   assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: directed vector table plus
// full-dump, stall, abort, reset and repeated-start sequences.
module tb_regfile_dump_reader;

   localparam int AW = 5;
   localparam int DW = 32;
`ifdef REGFILE_DUMP_SKIP_X0_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif
   localparam int LAST   = 31;
   localparam int NBEATS = LAST - FIRST + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, abort, ready;
   logic          busy, done, valid;
   logic [AW-1:0] rf_addr, out_addr;
   logic [DW-1:0] rf_data, out_data;
   logic [DW-1:0] rf [32];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign rf_data = rf[rf_addr];

   regfile_dump_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .abort_i     (abort),
      .busy_o      (busy),
      .done_o      (done),
      .rf_addr_o   (rf_addr),
      .rf_data_i   (rf_data),
      .out_valid_o (valid),
      .out_ready_i (ready),
      .out_addr_o  (out_addr),
      .out_data_o  (out_data)
   );

   function automatic logic [DW-1:0] exp_data(input int a);
      return (a == 0) ? 32'h0 : 32'h1000_0000 + 32'(a);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          start, abort, ready;
      logic          e_busy, e_valid, e_done;
      logic [AW-1:0] e_rf;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      logic          chk_beat;
   } vec_t;

   // Full dump: mode 0 = ready always 1, mode 1 = toggling ready with random 3-cycle stalls.
   task automatic run_dump(input int mode, input bit spam);
      int beats = 0, dones = 0, exp_a = FIRST, hs_i = -1, stall = 0, stray = 0;
      logic pv = 1'b0, phs = 1'b0;
      logic [AW-1:0] pa = '0;
      logic [DW-1:0] pd = '0;
      bit fin = 0, ord_ok = 1, stab_ok = 1, lat_ok = 1, done_ok = 1;
      @(negedge clk);
      start = 1'b1;
      ready = (mode == 0);
      for (int i = 1; i < 400 && !fin; i++) begin
         @(negedge clk);
         if (pv && !phs && (!valid || out_addr != pa || out_data != pd)) stab_ok = 0;
         if (done) begin
            dones++;
            if (i != hs_i + 1) done_ok = 0;
            fin = 1;
         end
         start = spam;
         if (mode == 0) ready = 1'b1;
         else if (stall > 0) begin ready = 1'b0; stall--; end
         else if ($urandom_range(0, 5) == 0) begin ready = 1'b0; stall = 2; end
         else ready = i[0];
         if (valid && ready) begin
            if (out_addr != AW'(exp_a) || out_data != exp_data(exp_a)) ord_ok = 0;
            if (mode == 0 && i != 2 + 2 * beats) lat_ok = 0;
            beats++;
            exp_a++;
            hs_i = i;
         end
         pv = valid; phs = valid && ready; pa = out_addr; pd = out_data;
      end
      start = 1'b0;
      check("dump_finished", fin, 1);
      check("dump_beats", beats, NBEATS);
      check("dump_done_count", dones, 1);
      check("dump_order_data", ord_ok, 1);
      check("dump_stall_stable", stab_ok, 1);
      check("dump_latency_spacing", lat_ok, 1);
      check("dump_done_after_last", done_ok, 1);
      @(negedge clk);
      check("dump_busy_after_fin", busy, 0);
      check("dump_done_one_cycle", done, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (valid || busy || done) stray++;
      end
      check("dump_no_second_dump", stray, 0);
      ready = 1'b0;
   endtask

   task automatic wait_beat(input int addr, output bit found);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (valid && out_addr == AW'(addr)) found = 1;
      end
   endtask

   vec_t vecs [8];
   bit   found;
   int   dcount;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = exp_data(i);
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_done", done, 0);
      check("rst_out_addr", out_addr, 0);
      check("rst_out_data", out_data, 0);
      check("rst_rf_addr", rf_addr, FIRST);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);

      // Uninterrupted dump at full throughput
      run_dump(0, 0);

      // Directed vector table: stall, handshake, abort with ready, abort+start in IDLE
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(FIRST),     '0,              '0,                     1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, AW'(FIRST),     '0,              '0,                     1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, AW'(FIRST),     AW'(FIRST),      exp_data(FIRST),        1'b1};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, AW'(FIRST),     AW'(FIRST),      exp_data(FIRST),        1'b1};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, AW'(FIRST + 1), '0,              '0,                     1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, AW'(FIRST + 1), AW'(FIRST + 1),  exp_data(FIRST + 1),    1'b1};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, AW'(FIRST),     '0,              '0,                     1'b0};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(FIRST),     '0,              '0,                     1'b0};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
         check($sformatf("vec%0d_valid", i), valid, vecs[i].e_valid);
         check($sformatf("vec%0d_done", i), done, vecs[i].e_done);
         check($sformatf("vec%0d_rf_addr", i), rf_addr, vecs[i].e_rf);
         if (vecs[i].chk_beat) begin
            check($sformatf("vec%0d_out_addr", i), out_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_data);
         end
         start = vecs[i].start; abort = vecs[i].abort; ready = vecs[i].ready;
      end
      start = 1'b0; abort = 1'b0; ready = 1'b0;

      // Dump with toggling ready and random stalls
      run_dump(1, 0);

      // Abort on the addr-5 beat while the sink is ready
      @(negedge clk);
      start = 1'b1; ready = 1'b1;
      wait_beat(5, found);
      check("abort_reached_addr5", found, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_valid_dropped", valid, 0);
      check("abort_busy", busy, 0);
      check("abort_rf_addr", rf_addr, FIRST);
      dcount = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || valid) dcount++;
      end
      check("abort_no_done", dcount, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("restart_valid", valid, 1);
      check("restart_addr", out_addr, FIRST);
      check("restart_data", out_data, exp_data(FIRST));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // Asynchronous reset while the addr-17 beat is valid
      start = 1'b1; ready = 1'b1;
      wait_beat(17, found);
      check("reset_reached_addr17", found, 1);
      rst_n = 1'b0;
      #1;
      check("arst_valid", valid, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_out_addr", out_addr, 0);
      check("arst_out_data", out_data, 0);
      check("arst_rf_addr", rf_addr, FIRST);
      @(negedge clk);
      rst_n = 1'b1; ready = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", valid, 0);

      // Repeated start during the dump and in the FIN cycle
      run_dump(0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
